// File: rtl/commutator_stage_ctrl_if.sv
//==============================================================================
// Module  : commutator_stage_ctrl_if
// Brief   : Handshake and data bundle between the stage-1 butterflies, the
//           delay-commutator-delay controller and the stage-2 butterflies.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface commutator_stage_ctrl_if #(
  parameter int WIDTH = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic signed [WIDTH-1:0] UI_real;
  logic signed [WIDTH-1:0] UI_imag;
  logic signed [WIDTH-1:0] LI_real;
  logic signed [WIDTH-1:0] LI_imag;
  logic signed [WIDTH-1:0] UO_real;
  logic signed [WIDTH-1:0] UO_imag;
  logic signed [WIDTH-1:0] LO_real;
  logic signed [WIDTH-1:0] LO_imag;
  logic                    out_valid;
  logic                    out_last;
  logic                    control_signal;
  logic                    busy;

  // Upstream/test side: drives samples, observes the reordered stream.
  modport master (
    output in_valid, in_last, UI_real, UI_imag, LI_real, LI_imag,
    input  in_ready, UO_real, UO_imag, LO_real, LO_imag,
    input  out_valid, out_last, control_signal, busy
  );

  // Controller side.
  modport slave (
    input  in_valid, in_last, UI_real, UI_imag, LI_real, LI_imag,
    output in_ready, UO_real, UO_imag, LO_real, LO_imag,
    output out_valid, out_last, control_signal, busy
  );
endinterface

`default_nettype wire

// File: rtl/commutator_stage_ctrl.sv
//==============================================================================
// Module  : commutator_stage_ctrl
// Brief   : Delay-commutator-delay controller for the 16-point stage of the
//           32-point IFFT. Owns both DELAY-deep delay lines, the advance
//           counter and the bypass/cross select, and sequences frame
//           fill and flush.
//           Optional sticky frame-length check: define COMM_CTRL_FRAME_CHECK_EN
//           to add the frame_err output.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module commutator_stage_ctrl #(
  parameter int WIDTH = 12,
  parameter int DELAY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  commutator_stage_ctrl_if.slave bus
`ifdef COMM_CTRL_FRAME_CHECK_EN
  ,
  output logic                   frame_err
`endif
);

  localparam int CW = $clog2(2 * DELAY);
  localparam int FW = $clog2(DELAY);
  localparam int PW = 2 * WIDTH;

  localparam logic [CW-1:0] c_depth    = CW'(DELAY);
  localparam logic [CW-1:0] c_fill_end = CW'(DELAY - 1);
  localparam logic [FW-1:0] c_flush_end = FW'(DELAY - 1);
`ifdef COMM_CTRL_FRAME_CHECK_EN
  localparam logic [CW-1:0] c_blk_end  = CW'(2 * DELAY - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_flush_cnt;
  logic            r_out_valid;
  logic            r_out_last;
  logic [PW-1:0]   r_a [DELAY];
  logic [PW-1:0]   r_b [DELAY];
  logic [PW-1:0]   r_uo;
  logic [PW-1:0]   r_lo;

  logic            w_ready;
  logic            w_accept;
  logic            w_advance;
  logic            w_sel;
  logic            w_out_valid_nxt;
  logic            w_out_last_nxt;
  logic [PW-1:0]   w_ui;
  logic [PW-1:0]   w_li;
  logic [PW-1:0]   w_up;
  logic [PW-1:0]   w_uo_nxt;
  logic [PW-1:0]   w_lo_path;

  // Handshake, select and next-state decode; IDLE always selects bypass
  // because the first accept of a frame is index 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_advance       = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_out_last_nxt  = 1'b0;
    w_ready         = (r_state != ST_FLUSH);
    w_accept        = bus.in_valid && w_ready && rst_n;
    w_sel           = (r_state == ST_IDLE) || (r_cnt < c_depth);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_advance   = 1'b1;
          w_state_nxt = bus.in_last ? ST_FLUSH : ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          w_advance = 1'b1;
          if (bus.in_last)               w_state_nxt = ST_FLUSH;
          else if (r_cnt == c_fill_end)  w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          w_advance       = 1'b1;
          w_out_valid_nxt = 1'b1;
          if (bus.in_last) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_advance       = 1'b1;
        w_out_valid_nxt = 1'b1;
        if (r_flush_cnt == c_flush_end) begin
          w_out_last_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Commutator: flush feeds zeros; upper path sees delay A's oldest entry.
  always_comb begin
    w_ui      = (r_state == ST_FLUSH) ? '0 : {bus.UI_real, bus.UI_imag};
    w_li      = (r_state == ST_FLUSH) ? '0 : {bus.LI_real, bus.LI_imag};
    w_up      = r_a[DELAY-1];
    w_uo_nxt  = w_sel ? w_up : w_li;
    w_lo_path = w_sel ? w_li : w_up;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Advance counter (restarts per frame), flush counter and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_flush_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      if (w_advance) r_cnt <= (r_state == ST_IDLE) ? CW'(1) : r_cnt + 1'b1;
      if (r_state == ST_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Delay lines A and B plus the output registers move only on an advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      r_uo <= '0;
      r_lo <= '0;
    end else if (w_advance) begin
      r_a[0] <= w_ui;
      r_b[0] <= w_lo_path;
      for (int i = 1; i < DELAY; i++) begin
        r_a[i] <= r_a[i-1];
        r_b[i] <= r_b[i-1];
      end
      r_uo <= w_uo_nxt;
      r_lo <= r_b[DELAY-1];
    end
  end

`ifdef COMM_CTRL_FRAME_CHECK_EN
  // Sticky flag: in_last anywhere other than the final index of a 2D block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else if (w_accept && bus.in_last &&
             (r_state != ST_RUN || r_cnt != c_blk_end))
      frame_err <= 1'b1;
  end
`endif

  assign bus.in_ready       = w_ready && rst_n;
  assign bus.control_signal = w_sel;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.out_valid      = r_out_valid;
  assign bus.out_last       = r_out_last;
  assign bus.UO_real        = r_uo[PW-1:WIDTH];
  assign bus.UO_imag        = r_uo[WIDTH-1:0];
  assign bus.LO_real        = r_lo[PW-1:WIDTH];
  assign bus.LO_imag        = r_lo[WIDTH-1:0];

endmodule

`default_nettype wire

// File: doc/commutator_stage_ctrl.md
Name: commutator_stage_ctrl

Overview:
- Delay-commutator-delay controller for the 16-point stage of the 32-point IFFT pipeline.
- Owns both D-deep delay lines and the sample counter, and drives the switch/bypass select: 1 = bypass, 0 = cross.
- Reorders two parallel complex S2.9 streams so that each output pair holds elements j and j+D of one input path.
- Sits between stage-1 butterfly outputs and stage-2 butterfly inputs; also sequences frame fill and flush.

Parameters:
- WIDTH, 12, bits per real/imag component (S2.9).
- DELAY, 8, delay-line depth D; power of two, at least 2. Counter width is log2(2D).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair present.
- in_ready  out  1  block accepts a pair; accept = in_valid & in_ready.
- in_last  in  1  qualifies the final pair of a frame.
- UI_real, UI_imag, LI_real, LI_imag  in  WIDTH each  upper/lower input, signed.
- UO_real, UO_imag, LO_real, LO_imag  out  WIDTH each  upper/lower output, registered.
- out_valid  out  1  output pair valid, one cycle per advance.
- out_last  out  1  final output pair of the frame.
- control_signal  out  1  current commutator select: 1 bypass, 0 switch.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all delay-line registers and data outputs=0, out_valid=0, out_last=0, in_ready=0 while in reset, control_signal=1.
- Advance: a pipeline step. Occurs on an accept, or once per cycle in FLUSH. No other cycle changes any register.
- cnt: advance counter, increments mod 2D on every advance, cleared when a frame starts. control_signal = 1 when cnt<D, else 0.
- Datapath per advance at index t:
  - Upper delay A shifts in UI. The commutator sees UI'=A output (u delayed D) and LI'=LI.
  - Bypass: UO'=UI', LO'=LI'. Switch: UO'=LI', LO'=UI'.
  - UO register loads UO'. LO'-path delay B (depth D) shifts in LO'; LO register loads the B output.
  - Resulting order per 2D-pair block: outputs t∈[D,2D) carry (LO,UO)=(l_j,l_{D+j}); the next D advances carry (u_j,u_{D+j}).
- FSM:
  - IDLE: in_ready=1. The first accept clears cnt to 1, ends in FILL, and is ignored for output validity.
  - FILL: in_ready=1. Accepts 0..D-1 produce out_valid=0. After accept D-1 the state goes to RUN.
  - RUN: in_ready=1. Every accept yields out_valid=1 on the next cycle. An accept with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0. Exactly D internal advances with UI/LI treated as 0, each with out_valid=1. out_last=1 on the last one, then IDLE.
- Latency: D advances from input sample to its output slot, plus 1 cycle output register.
- Frame length: must be a multiple of 2D.
  - Without the optional feature, in_last at any phase still enters FLUSH.
  - Output content is then undefined, but the handshake still terminates.
  - in_last during FILL jumps straight to FLUSH.
- Gaps in in_valid freeze all registers; out_valid=0 on those cycles.
- A new frame is accepted only in IDLE, so back-to-back frames incur D flush cycles.
- Reset mid-frame discards all state; the next accept starts a fresh frame.

Optional Feature:
- Macro: COMM_CTRL_FRAME_CHECK_EN.
- When defined:
  - Adds port frame_err (out, 1), reset 0.
  - frame_err sets sticky when in_last is accepted with cnt≠2D-1, or when in_last is accepted in FILL.
  - Cleared only by rst_n.
  - FSM behaviour is unchanged.
- When undefined: the port does not exist and no check logic is built.

Test Plan:
- D=8, one 16-pair frame, contiguous valid, u_k=k, l_k=16+k, imag=-real:
  - Outputs 0-7: (LO,UO)=(16+j,24+j).
  - Flush outputs: (j,8+j).
  - out_last on (7,15).
  - in_ready low exactly 8 cycles.
- Same frame with in_valid dropped every other cycle -> identical output sequence; out_valid only on cycles after accepts.
- Two 16-pair blocks in one 32-pair frame:
  - control_signal pattern is 1×8, 0×8, 1×8, 0×8, then 1 during flush.
  - Block-0 u-pairs are interleaved correctly before block-1 l-pairs.
- rst_n pulsed low after 5 accepts -> outputs and out_valid are 0 immediately; a following full frame matches the first scenario.
- With COMM_CTRL_FRAME_CHECK_EN defined: in_last on pair 11 -> frame_err=1 and held; flush still 8 cycles; a clean frame afterwards keeps frame_err=1 until reset.
